// File: rtl/mem_wb_regfile_if.sv
// Bus between the MEM stage / ID-stage read logic and the writeback block.
// The master drives MEM-stage results, pipeline control and read addresses;
// the slave (writeback block) returns read data, the pending write and the
// retire count.
interface mem_wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Pipeline control
  logic              stall;
  logic              flush;
  // MEM-stage results and control for the instruction entering WB
  logic              in_valid;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic [ADDR_W-1:0] in_write_reg;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;
  // ID-stage read ports
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  // Pending write (for forwarding) and retire count
  logic              wb_valid;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic [31:0]       retired;

  modport master (
    output stall, flush, in_valid, in_mem_to_reg, in_reg_write, in_write_reg,
           in_alu_result, in_mem_data, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_valid, wb_reg_write, wb_write_reg,
           wb_write_data, retired
  );

  modport slave (
    input  stall, flush, in_valid, in_mem_to_reg, in_reg_write, in_write_reg,
           in_alu_result, in_mem_data, rs_addr, rt_addr,
    output rs_data, rt_data, wb_valid, wb_reg_write, wb_write_reg,
           wb_write_data, retired
  );
endinterface

// File: rtl/mem_wb_regfile.sv
// Writeback end of the five-stage pipeline: MEM/WB pipeline register,
// writeback data select, 32-entry register file with two bypassed read
// ports, and a retired-instruction counter.
module mem_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  mem_wb_regfile_if.slave bus
);

  localparam int NumRegs = 1 << ADDR_W;

  typedef struct packed {
    logic              valid;
    logic              memToReg;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] memData;
  } memWbT;

  memWbT             wbQ;
  logic [DATA_W-1:0] regs [NumRegs];
  logic [31:0]       retiredCnt;

  logic [DATA_W-1:0] wbWriteData;
  logic              wbRegWrite;
  logic              commit;
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;

  // Writeback data select and effective write enable; a write is only
  // committed on an edge where the pipeline is not stalled.
  assign wbWriteData = wbQ.memToReg ? wbQ.memData : wbQ.aluResult;
  assign wbRegWrite  = wbQ.valid & wbQ.regWrite & (wbQ.writeReg != '0);
  assign commit      = wbRegWrite & ~bus.stall;

  // MEM/WB pipeline register: stall holds, flush inserts a bubble, else load.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbQ <= '0;
    end else if (!bus.stall) begin
      if (bus.flush) begin
        // Data fields are don't-care in a bubble, so they are left as-is.
        wbQ.valid    <= 1'b0;
        wbQ.regWrite <= 1'b0;
      end else begin
        wbQ <= '{valid:     bus.in_valid,
                 memToReg:  bus.in_mem_to_reg,
                 regWrite:  bus.in_reg_write,
                 writeReg:  bus.in_write_reg,
                 aluResult: bus.in_alu_result,
                 memData:   bus.in_mem_data};
      end
    end
  end

  // Register file commit; entry 0 is never written so it stays zero.
  // NOTE: the register file must read zero after reset, so every entry is
  // cleared by the asynchronous reset (this keeps it out of RAM macros).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wbQ.writeReg] <= wbWriteData;
    end
  end

  // Retired-instruction counter: one per unstalled edge with a valid
  // instruction in WB, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredCnt <= '0;
    end else if (!bus.stall && wbQ.valid) begin
      retiredCnt <= retiredCnt + 32'd1;
    end
  end

  // Read ports: $0 reads zero, a committing write to the same index is
  // bypassed, otherwise storage is returned.
  // NOTE: each output is given a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    rsData = regs[bus.rs_addr];
    if (commit && (bus.rs_addr == wbQ.writeReg)) rsData = wbWriteData;
    if (bus.rs_addr == '0) rsData = '0;

    rtData = regs[bus.rt_addr];
    if (commit && (bus.rt_addr == wbQ.writeReg)) rtData = wbWriteData;
    if (bus.rt_addr == '0) rtData = '0;
  end

  assign bus.rs_data       = rsData;
  assign bus.rt_data       = rtData;
  assign bus.wb_valid      = wbQ.valid;
  assign bus.wb_reg_write  = wbRegWrite;
  assign bus.wb_write_reg  = wbQ.writeReg;
  assign bus.wb_write_data = wbWriteData;
  assign bus.retired       = retiredCnt;

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Self-checking bench for mem_wb_regfile. A driver issues one cycle of
// stimulus at a time and pushes the expected outputs for that cycle into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_mem_wb_regfile;

  logic clk;
  logic rst_n;

  mem_wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mem_wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle
  typedef struct {
    logic        valid;
    logic        regWrite;
    logic        dataKnown;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] retired;
  } expT;

  // Reference model: the instruction sitting in WB, the architectural
  // register file and the retire count.
  typedef struct {
    logic        valid;
    logic        memToReg;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] alu;
    logic [31:0] mem;
  } instT;

  instT        pend;
  logic        pendKnown;
  logic [31:0] arch [32];
  logic [31:0] mdlRetired;
  expT         sbQueue [$];

  int nCompared;
  int nMismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdlData();
    return pend.memToReg ? pend.mem : pend.alu;
  endfunction

  function automatic logic mdlWrites();
    return pend.valid && pend.regWrite && (pend.writeReg != 5'd0);
  endfunction

  function automatic logic [31:0] mdlRead(input logic [4:0] addr, input logic st);
    if (addr == 5'd0) return 32'd0;
    if (!st && mdlWrites() && addr == pend.writeReg) return mdlData();
    return arch[addr];
  endfunction

  task automatic mdlReset();
    pend       = '{valid: 1'b0, memToReg: 1'b0, regWrite: 1'b0, writeReg: 5'd0, alu: 32'd0, mem: 32'd0};
    pendKnown  = 1'b1;
    mdlRetired = 32'd0;
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
  endtask

  // Apply inputs for the current cycle and queue the expected outputs.
  task automatic drive(input logic st, input logic fl, input logic v, input logic m2r,
                       input logic rw, input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] ra, input logic [4:0] rb);
    expT e;
    bus.stall         = st;
    bus.flush         = fl;
    bus.in_valid      = v;
    bus.in_mem_to_reg = m2r;
    bus.in_reg_write  = rw;
    bus.in_write_reg  = wr;
    bus.in_alu_result = alu;
    bus.in_mem_data   = mem;
    bus.rs_addr       = ra;
    bus.rt_addr       = rb;
    e.valid     = pend.valid;
    e.regWrite  = mdlWrites();
    e.dataKnown = pendKnown;
    e.writeReg  = pend.writeReg;
    e.writeData = mdlData();
    e.rsData    = mdlRead(ra, st);
    e.rtData    = mdlRead(rb, st);
    e.retired   = mdlRetired;
    sbQueue.push_back(e);
  endtask

  // Advance one rising edge and update the model from the applied inputs.
  task automatic tick();
    @(posedge clk);
    if (!bus.stall) begin
      if (mdlWrites()) arch[pend.writeReg] = mdlData();
      if (pend.valid) mdlRetired = mdlRetired + 32'd1;
      if (bus.flush) begin
        pend.valid    = 1'b0;
        pend.regWrite = 1'b0;
        pendKnown     = 1'b0;
      end else begin
        pend = '{valid: bus.in_valid, memToReg: bus.in_mem_to_reg, regWrite: bus.in_reg_write,
                 writeReg: bus.in_write_reg, alu: bus.in_alu_result, mem: bus.in_mem_data};
        pendKnown = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, ra, rb);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".wb_valid"},      {31'd0, bus.wb_valid},     32'd0);
    check({tag, ".wb_reg_write"},  {31'd0, bus.wb_reg_write}, 32'd0);
    check({tag, ".wb_write_reg"},  {27'd0, bus.wb_write_reg}, 32'd0);
    check({tag, ".wb_write_data"}, bus.wb_write_data,         32'd0);
    check({tag, ".rs_data"},       bus.rs_data,               32'd0);
    check({tag, ".rt_data"},       bus.rt_data,               32'd0);
    check({tag, ".retired"},       bus.retired,               32'd0);
  endtask

  // Monitor: compare the DUT against the queued expectation mid-cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        check("sb.wb_valid",     {31'd0, bus.wb_valid},     {31'd0, e.valid});
        check("sb.wb_reg_write", {31'd0, bus.wb_reg_write}, {31'd0, e.regWrite});
        if (e.dataKnown) begin
          check("sb.wb_write_reg",  {27'd0, bus.wb_write_reg}, {27'd0, e.writeReg});
          check("sb.wb_write_data", bus.wb_write_data,         e.writeData);
        end
        check("sb.rs_data", bus.rs_data, e.rsData);
        check("sb.rt_data", bus.rt_data, e.rtData);
        check("sb.retired", bus.retired, e.retired);
      end
    end
  end

  // Driver: directed test-plan items, then randomized traffic.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    mdlReset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.in_mem_to_reg = 1'b0; bus.in_reg_write = 1'b0; bus.in_write_reg = 5'd0;
    bus.in_alu_result = 32'd0; bus.in_mem_data = 32'd0;
    bus.rs_addr = 5'd1; bus.rt_addr = 5'd2;
    #3;
    checkAllZero("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU writeback to r5, bypass then storage
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 5'd0, 5'd0);
    tick();
    idle(5'd5, 5'd0);
    #1;
    check("alu.wb_write_data", bus.wb_write_data, 32'h0000_1234);
    check("alu.bypass",        bus.rs_data,       32'h0000_1234);
    tick();
    idle(5'd5, 5'd5);
    #1;
    check("alu.storage", bus.rs_data, 32'h0000_1234);
    check("alu.retired", bus.retired, 32'd1);
    tick();

    // Load writeback to r8, then the same load aimed at $0
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h1111_1111, 32'hCAFE_F00D, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h1111_1111, 32'hCAFE_F00D, 5'd8, 5'd0);
    #1;
    check("load.bypass", bus.rs_data, 32'hCAFE_F00D);
    tick();
    idle(5'd8, 5'd0);
    #1;
    check("load.r0_wb_reg_write", {31'd0, bus.wb_reg_write}, 32'd0);
    check("load.r8_storage",      bus.rs_data,               32'hCAFE_F00D);
    check("load.r0_reads_zero",   bus.rt_data,               32'd0);
    tick();

    // Stall: r3 write held three cycles, commits once on release
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0077, 32'd0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'hBAD0_0000, 32'd0, 5'd3, 5'd0);
      #1;
      check("stall.no_bypass", bus.rs_data, 32'd0);
      tick();
    end
    idle(5'd3, 5'd0);
    #1;
    check("stall.release_bypass", bus.rs_data, 32'h0000_0077);
    tick();
    idle(5'd3, 5'd0);
    tick();

    // Flush a valid write to r9
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 32'd0, 5'd0, 5'd0);
    tick();
    idle(5'd9, 5'd0);
    #1;
    check("flush.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    idle(5'd9, 5'd0);
    #1;
    check("flush.r9_zero", bus.rs_data, 32'd0);
    tick();

    // Flush during stall is dropped: r10 write survives and commits
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_00AA, 32'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_00BB, 32'd0, 5'd10, 5'd11);
    tick();
    idle(5'd10, 5'd0);
    #1;
    check("flushstall.wb_write_reg", {27'd0, bus.wb_write_reg}, 32'd10);
    tick();
    idle(5'd10, 5'd11);
    #1;
    check("flushstall.r10", bus.rs_data, 32'h0000_00AA);
    tick();

    // Reset mid-operation with an r12 write in flight
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0099, 32'd0, 5'd0, 5'd0);
    tick();
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd8;
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    mdlReset();
    #1 rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      idle(5'(i), 5'(32 - i));
      tick();
    end

    // Retire counter wrap from a preloaded all-ones value
    force dut.retiredCnt = 32'hFFFF_FFFF;
    #1 release dut.retiredCnt;
    mdlRetired = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    #1;
    check("wrap.ffffffff", bus.retired, 32'hFFFF_FFFF);
    tick();
    idle(5'd0, 5'd0);
    #1;
    check("wrap.zero", bus.retired, 32'd0);
    tick();

    // Randomized traffic over a small register window to provoke bypass hits
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    idle(5'd0, 5'd0);
    @(negedge clk);
    #1;
    check("sb.drained", sbQueue.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_wb_regfile.md
# mem_wb_regfile

Writeback end of the five-stage MIPS pipeline: it consumes the MemtoReg/RegWrite control pair produced for each instruction, together with the MEM-stage results. It holds the MEM/WB pipeline register, selects the writeback data and commits it to the 32-entry register file. It also serves the two ID-stage read ports with same-cycle write bypass, exports the pending write for forwarding and counts retired instructions.

## Interface

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W entries)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the MEM/WB register; suppress the write and the retire count
- flush  in  1  load a bubble into MEM/WB (ignored while stall=1)
- in_valid  in  1  MEM stage holds a real instruction
- in_mem_to_reg  in  1  1: write mem data; 0: write ALU result
- in_reg_write  in  1  instruction writes a register
- in_write_reg  in  ADDR_W  destination register index
- in_alu_result  in  DATA_W  ALU result from MEM stage
- in_mem_data  in  DATA_W  load data from MEM stage
- rs_addr, rt_addr  in  ADDR_W  ID-stage read addresses
- rs_data, rt_data  out  DATA_W  read data, combinational, with bypass
- wb_valid  out  1  MEM/WB holds a real instruction
- wb_reg_write  out  1  effective write enable (wb_valid & reg_write & write_reg≠0)
- wb_write_reg  out  ADDR_W  pending destination
- wb_write_data  out  DATA_W  pending write data (muxed)
- retired  out  32  count of instructions retired since reset

## Operation

- MEM/WB register fields: valid, mem_to_reg, reg_write, write_reg, alu_result, mem_data.
- Update priority at each rising edge:
  - stall=1: hold all fields.
  - else flush=1: valid=0, reg_write=0; data fields don't-care.
  - else: load all in_* inputs.
- wb_write_data = mem_to_reg ? mem_data : alu_result.
- wb_reg_write = valid & reg_write & (write_reg≠0).
- Register-file commit happens at a rising edge with stall=0 and wb_reg_write=1: regs[wb_write_reg] ← wb_write_data. The commit and the MEM/WB reload occur on the same edge.
- Register 0 reads 0 always and is never written.
- Read ports, per port:
  - addr=0 → 0.
  - else addr==wb_write_reg and wb_reg_write=1 and stall=0 → wb_write_data (bypass).
  - else regs[addr].
- Bypass is suppressed under stall because no commit occurs that cycle.
- retired increments by 1 at each edge with stall=0 and valid=1, whether or not the instruction writes. It wraps 0xFFFFFFFF→0.

## Timing

- Reset (rst_n=0, asynchronous): all MEM/WB fields 0; all 32 registers 0; retired=0. Outputs during reset: wb_valid=0, wb_reg_write=0, wb_write_reg=0, wb_write_data=0, rs_data=rt_data=0.
- Latency: inputs sampled at edge N appear on wb_* after edge N. Commit occurs at edge N+1 if stall=0; otherwise at the first later edge with stall=0. A plain register read sees the value after the commit edge; the bypass path sees it during the cycle before that edge.
- Stall for k cycles: wb_* outputs are stable, no commit and no count. The held instruction commits exactly once, on release.
- flush together with stall: stall wins; the flush request is dropped and must be reasserted.
- Reset asserted mid-operation: the in-flight WB write is lost and all state clears immediately. The first edge after rst_n rises loads MEM/WB normally.
- Back-to-back writes to the same register: each commits in order; the later value wins.

## Test plan

- Reset: pulse rst_n low between edges → all outputs 0 immediately; a read of regs 1..31 returns 0.
- ALU writeback: in_valid=1, reg_write=1, mem_to_reg=0, write_reg=5, alu=0x0000_1234, mem=0xDEAD_BEEF → wb_write_data=0x1234. rs_addr=5 returns 0x1234 via bypass that cycle and from storage after the next edge. retired=1.
- Load writeback and $0: mem_to_reg=1, write_reg=8, mem=0xCAFE_F00D → r8=0xCAFE_F00D. Same instruction with write_reg=0 → wb_reg_write=0; r0 still reads 0.
- Stall: load write_reg=3 data 0x77, hold stall=1 for 3 cycles → r3 unchanged, retired unchanged, no bypass. On release, r3=0x77 and retired increments once.
- Flush: flush=1 with a valid write to r9=0x55 → wb_valid=0, r9 stays 0, retired unchanged. Flush with stall=1 → held instruction kept and committed on release.
- Counter wrap: force 0xFFFF_FFFF retirements (or preload via backdoor) then one more valid instruction → retired=0.
